// File: rtl/kpn_adder_process.sv
// KPN adder process: blocking read of one token from each of two input queues,
// adds the pair and performs a blocking write of the sum into an output queue.
module kpn_adder_process #(
    parameter int unsigned BITS_NUMBER = 16,
    parameter int unsigned COUNT_BITS  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   empty_1,
    input  logic                   empty_2,
    input  logic [BITS_NUMBER-1:0] input_1,
    input  logic [BITS_NUMBER-1:0] input_2,
    output logic                   rd_1,
    output logic                   rd_2,
    input  logic                   full,
    output logic                   wr,
    output logic [BITS_NUMBER-1:0] output_1,
    output logic                   overflow,
    output logic [COUNT_BITS-1:0]  token_count
);

    localparam int unsigned SUM_W = BITS_NUMBER + 1;

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic                   rd_next;
    logic                   wr_next;
    logic                   overflow_next;
    logic [BITS_NUMBER-1:0] output_next;
    logic [COUNT_BITS-1:0]  count_next;
    logic [SUM_W-1:0]       sum;

    assign sum = SUM_W'(input_1) + SUM_W'(input_2);

    // Outputs are computed one edge ahead so each strobe is high exactly in
    // the cycle its state occupies; wr is granted on the full value sampled
    // at the edge that raises it.
    always_comb begin
        state_next    = state;
        rd_next       = 1'b0;
        wr_next       = 1'b0;
        output_next   = output_1;
        overflow_next = overflow;
        count_next    = token_count;
        unique case (state)
            S_WAIT: begin
                if (!empty_1 && !empty_2) begin
                    state_next = S_READ;
                    rd_next    = 1'b1;
                end
            end
            S_READ: begin
                state_next = S_LATCH;
            end
            S_LATCH: begin
                state_next  = S_WRITE;
                output_next = sum[BITS_NUMBER-1:0];
                if (sum[BITS_NUMBER]) begin
                    overflow_next = 1'b1;
                end
                if (!full) begin
                    wr_next    = 1'b1;
                    count_next = token_count + COUNT_BITS'(1);
                end
            end
            S_WRITE: begin
                if (wr) begin
                    state_next = S_WAIT;
                end else if (!full) begin
                    wr_next    = 1'b1;
                    count_next = token_count + COUNT_BITS'(1);
                end
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_WAIT;
            rd_1        <= 1'b0;
            rd_2        <= 1'b0;
            wr          <= 1'b0;
            output_1    <= '0;
            overflow    <= 1'b0;
            token_count <= '0;
        end else begin
            state       <= state_next;
            rd_1        <= rd_next;
            rd_2        <= rd_next;
            wr          <= wr_next;
            output_1    <= output_next;
            overflow    <= overflow_next;
            token_count <= count_next;
        end
    end

endmodule

// File: tb/tb_kpn_adder_process.sv
// Bench for kpn_adder_process: emulates the two input queues, models the
// expected sum stream and checks every read/write handshake.
module tb_kpn_adder_process;

    localparam int unsigned BW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned NP = 60;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          empty_1;
    logic          empty_2;
    logic [BW-1:0] input_1;
    logic [BW-1:0] input_2;
    logic          rd_1;
    logic          rd_2;
    logic          full;
    logic          wr;
    logic [BW-1:0] output_1;
    logic          overflow;
    logic [CW-1:0] token_count;

    int unsigned vectors;
    int unsigned miscompares;

    // Queue contents, expected (unwrapped) sums in order, and expected status.
    int unsigned q1[$];
    int unsigned q2[$];
    int unsigned exp_q[$];
    int unsigned exp_cnt;
    bit          exp_ovf;

    int unsigned p1;
    int unsigned p2;

    kpn_adder_process #(
        .BITS_NUMBER(BW),
        .COUNT_BITS (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .empty_1    (empty_1),
        .empty_2    (empty_2),
        .input_1    (input_1),
        .input_2    (input_2),
        .rd_1       (rd_1),
        .rd_2       (rd_2),
        .full       (full),
        .wr         (wr),
        .output_1   (output_1),
        .overflow   (overflow),
        .token_count(token_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_empties();
        empty_1 = (q1.size() == 0);
        empty_2 = (q2.size() == 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
    endtask

    // One clock: queue pops on a sampled rd, then handshake and result checks.
    task automatic tick();
        logic        rd_was;
        logic        wr_was;
        logic        full_was;
        logic        e1_was;
        logic        e2_was;
        int unsigned a;
        int unsigned b;
        int unsigned e;
        rd_was   = rd_1;
        wr_was   = wr;
        full_was = full;
        e1_was   = empty_1;
        e2_was   = empty_2;
        @(posedge clk);
        #1;
        if (rd_was === 1'b1) begin
            a = (q1.size() > 0) ? q1.pop_front() : 0;
            b = (q2.size() > 0) ? q2.pop_front() : 0;
            input_1 = BW'(a);
            input_2 = BW'(b);
            exp_q.push_back(a + b);
        end
        if (rd_1 === 1'b1 || rd_2 === 1'b1) begin
            check("rd_pair", 32'({rd_1, rd_2}), 32'(2'b11));
            check("rd_guard", 32'({e1_was, e2_was, rd_was}), 32'(3'b000));
        end
        if (wr === 1'b1) begin
            check("wr_guard", 32'({full_was, wr_was}), 32'(2'b00));
            check("wr_pending", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_cnt++;
                if (e > 32'h0000_FFFF) exp_ovf = 1'b1;
                check("wr_sum", 32'(output_1), e & 32'h0000_FFFF);
                check("wr_ovf", 32'(overflow), 32'(exp_ovf));
                check("wr_cnt", 32'(token_count), exp_cnt & 32'h0000_FFFF);
            end
        end
        drive_empties();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        p1          = 0;
        p2          = 0;
        full        = 1'b0;
        input_1     = '0;
        input_2     = '0;
        model_reset();

        // Reset with data waiting in both queues
        reset_n = 1'b0;
        q1.push_back(3);
        q2.push_back(4);
        drive_empties();
        repeat (2) begin
            tick();
            check("rst_rd", 32'({rd_1, rd_2}), 32'(0));
            check("rst_wr", 32'(wr), 32'(0));
            check("rst_out", 32'(output_1), 32'(0));
            check("rst_ovf", 32'(overflow), 32'(0));
            check("rst_cnt", 32'(token_count), 32'(0));
        end
        model_reset();

        // Basic add 3 + 4
        reset_n = 1'b1;
        tick();
        check("add_rd_on", 32'({rd_1, rd_2}), 32'(2'b11));
        tick();
        check("add_rd_off", 32'({rd_1, rd_2}), 32'(0));
        tick();
        check("add_sum", 32'(output_1), 32'(7));
        check("add_wr_on", 32'(wr), 32'(1));
        check("add_cnt", 32'(token_count), 32'(1));
        tick();
        check("add_wr_off", 32'(wr), 32'(0));

        // One-sided data never produces a read
        q1.push_back(5);
        drive_empties();
        repeat (10) begin
            tick();
            check("one_side_rd", 32'({rd_1, rd_2}), 32'(0));
        end
        q2.push_back(6);
        drive_empties();
        tick();
        check("one_side_pair", 32'({rd_1, rd_2}), 32'(2'b11));
        repeat (2) tick();
        check("one_side_sum", 32'(output_1), 32'(11));
        check("one_side_wr", 32'(wr), 32'(1));
        tick();

        // Backpressure holds the sum until full drops
        full = 1'b1;
        q1.push_back(16'h0008);
        q2.push_back(16'h0008);
        drive_empties();
        repeat (3) tick();
        check("bp_latch", 32'(output_1), 32'(16'h0010));
        repeat (5) begin
            tick();
            check("bp_wr_low", 32'(wr), 32'(0));
            check("bp_hold", 32'(output_1), 32'(16'h0010));
        end
        full = 1'b0;
        tick();
        check("bp_wr_on", 32'(wr), 32'(1));
        check("bp_cnt", 32'(token_count), 32'(3));
        tick();
        check("bp_wr_off", 32'(wr), 32'(0));

        // Carry out sets the sticky overflow flag
        q1.push_back(16'hFFFF);
        q2.push_back(16'h0002);
        q1.push_back(1);
        q2.push_back(1);
        drive_empties();
        repeat (10) tick();
        check("ovf_sum", 32'(output_1), 32'(2));
        check("ovf_sticky", 32'(overflow), 32'(1));
        check("ovf_cnt", 32'(token_count), 32'(5));

        // Reset while the pair sits in the latch stage
        q1.push_back(7);
        q2.push_back(8);
        drive_empties();
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        check("mid_rst_wr", 32'(wr), 32'(0));
        check("mid_rst_rd", 32'({rd_1, rd_2}), 32'(0));
        check("mid_rst_cnt", 32'(token_count), 32'(0));
        check("mid_rst_ovf", 32'(overflow), 32'(0));
        model_reset();
        reset_n = 1'b1;
        q1.push_back(1);
        q2.push_back(2);
        drive_empties();
        repeat (5) tick();
        check("resume_sum", 32'(output_1), 32'(3));
        check("resume_cnt", 32'(token_count), 32'(1));

        // Randomized traffic with random backpressure
        for (int t = 0; t < 600; t++) begin
            if (p1 < NP && $urandom_range(0, 1) == 1) begin
                q1.push_back($urandom_range(0, 16'hFFFF));
                p1++;
            end
            if (p2 < NP && $urandom_range(0, 1) == 1) begin
                q2.push_back($urandom_range(0, 16'hFFFF));
                p2++;
            end
            full = ($urandom_range(0, 3) == 0);
            drive_empties();
            tick();
        end
        full = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (exp_q.size() == 0 && (q1.size() == 0 || q2.size() == 0) && wr === 1'b0)
                break;
            tick();
        end
        repeat (2) tick();
        check("drain_pending", 32'(exp_q.size()), 32'(0));
        check("drain_queues", 32'(q1.size() + q2.size()), 32'(0));
        check("drain_cnt", 32'(token_count), exp_cnt & 32'h0000_FFFF);
        check("drain_ovf", 32'(overflow), 32'(exp_ovf));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kpn_adder_process.md
Name: kpn_adder_process

Overview:
- Downstream KPN process node that consumes tokens from two queue_module FIFOs.
- Performs a blocking read of one token from each input queue, adds the pair, and performs a blocking write of the sum into an output queue.
- Implements Kahn semantics: it never reads a partial pair and never drops a result when the output queue is full.

Parameters:
- BITS_NUMBER, 16: token width, matching the queue_module BITS_NUMBER of all connected queues.
- COUNT_BITS, 16: width of the produced-token counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- empty_1  input  1  input queue 1 has no tokens.
- empty_2  input  1  input queue 2 has no tokens.
- input_1  input  BITS_NUMBER  queue 1 data (queue output_1); valid the cycle after rd_1.
- input_2  input  BITS_NUMBER  queue 2 data; valid the cycle after rd_2.
- rd_1  output  1  read strobe to queue 1.
- rd_2  output  1  read strobe to queue 2.
- full  input  1  output queue cannot accept a token.
- wr  output  1  write strobe to output queue.
- output_1  output  BITS_NUMBER  sum token presented to output queue.
- overflow  output  1  sticky flag: some sum carried out of BITS_NUMBER.
- token_count  output  COUNT_BITS  number of tokens written since reset.

Behaviour:
- Reset (reset_n=0 at a rising edge) forces the following, regardless of state:
  - state=S_WAIT, rd_1=rd_2=0, wr=0;
  - output_1=0, overflow=0, token_count=0.
- Reset mid-operation:
  - A token already read but not yet written is lost.
  - No rd or wr pulse is emitted in the reset cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states and transitions:
  - S_WAIT: rd/wr low. If empty_1=0 AND empty_2=0, go to S_READ; otherwise stay. It never reads only one queue.
  - S_READ: rd_1=rd_2=1 for exactly this one cycle. Next state is S_LATCH unconditionally.
  - S_LATCH: rd low. At the end of this cycle, register output_1 = (input_1 + input_2) mod 2^BITS_NUMBER. If the carry-out is 1, set overflow (sticky until reset). Next state is S_WRITE.
  - S_WRITE: if full=0, assert wr for one cycle, increment token_count, and go to S_WAIT. If full=1, keep wr low, hold output_1 stable, and stay.
- wr is asserted only in a cycle where the sampled full=0. Exactly one wr pulse is produced per rd pair.
- Latency, with both empty flags low sampled at edge k:
  - rd_1/rd_2 high in cycle k+1;
  - output_1 updated at edge k+2;
  - earliest wr high in cycle k+3.
- Maximum throughput is one token per 4 cycles.
- output_1 holds its last value after a write until the next S_LATCH.
- token_count wraps from 2^COUNT_BITS-1 to 0 with no flag.
- empty flags changing while in S_READ, S_LATCH or S_WRITE are ignored.
- full deasserting and reasserting while in S_WRITE: the decision is made purely on the full value sampled at each edge.
- Arithmetic is unsigned. Two's-complement wrap is implicit.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with empty_1=empty_2=0 -> rd_1, rd_2, wr, output_1, overflow and token_count all 0 throughout.
- Basic add: queues hold 3 and 4, full=0; release reset at edge 0 -> rd_1=rd_2=1 in cycle 1 only, output_1=7 from edge 2, wr=1 in cycle 3 only, token_count=1.
- One-sided data: empty_1=0, empty_2=1 for 10 cycles -> rd_1 stays 0 the whole time. Then set empty_2=0 -> both rd strobes pulse together on the next cycle.
- Backpressure: full=1 during S_WRITE for 5 cycles with sum 0x0010 -> wr=0 and output_1=0x0010 held. Drop full -> wr pulses exactly once on the next cycle.
- Overflow: 16'hFFFF + 16'h0002 -> output_1=16'h0001 and overflow=1. A following 1+1 gives output_1=2 with overflow still 1.
- Reset mid-op: assert reset_n=0 in S_LATCH -> no wr pulse, token_count=0. Operation resumes cleanly from S_WAIT afterwards.
